pixel_stream_tx: RTL and testbench
==================================

PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning pixels per line (2..4095).
REQ-002 SHALL have parameter IMG_H, default 480, meaning lines per frame (1..4095).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port pix_valid_i  input  1  parallel pixel offered.
REQ-006 SHALL have port pix_ready_o  output  1  parallel pixel accepted when high with pix_valid_i.
REQ-007 SHALL have port pix_data_i  input  24  pixel, R[23:16] G[15:8] B[7:0].
REQ-008 SHALL have port m_axis_tvalid  output  1  AXI-Stream byte valid.
REQ-009 SHALL have port m_axis_tready  input  1  AXI-Stream sink ready.
REQ-010 SHALL have port m_axis_tdata  output  8  serialized colour byte.
REQ-011 SHALL have port m_axis_tlast  output  1  end-of-line marker.
REQ-012 SHALL have port m_axis_tuser  output  1  start-of-frame marker (present only with PIXEL_TX_SOF_EN).
REQ-013 SHALL have port frame_done_o  output  1  one-cycle end-of-frame pulse.

Function
REQ-014 SHALL serialize each accepted pixel into three bytes, order R, G, B, on m_axis_tdata.
REQ-015 SHALL implement FSM states EMPTY, SEND_R, SEND_G, SEND_B; EMPTY->SEND_R on pixel accept; R->G, G->B on byte handshake (tvalid&&tready); B->SEND_R on handshake with simultaneous pixel accept, else B->EMPTY on handshake.
REQ-016 SHALL drive pix_ready_o = (state==EMPTY) || (state==SEND_B && m_axis_tready), giving zero-bubble back-to-back pixels.
REQ-017 SHALL register the accepted pixel; R byte valid on the cycle after acceptance (latency 1 cycle).
REQ-018 SHALL keep m_axis_tvalid high and tdata/tlast/tuser stable while tvalid && !tready.
REQ-019 SHALL sustain one byte per cycle (one pixel per 3 cycles) under continuous valid and tready.
REQ-020 SHALL keep column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1), advancing x on SEND_B handshake, wrapping x to 0 and incrementing y at x==IMG_W-1, wrapping y to 0 at y==IMG_H-1.
REQ-021 SHALL assert m_axis_tlast only with the B byte of pixel x==IMG_W-1.
REQ-022 SHALL pulse frame_done_o for one cycle the cycle after the B-byte handshake of pixel (IMG_W-1, IMG_H-1).
REQ-023 SHALL drive m_axis_tvalid low and ignore m_axis_tready in EMPTY.

Reset
REQ-024 SHALL on rst_n low immediately force state EMPTY, x=0, y=0, pixel register 0, and all outputs (pix_ready_o excepted) 0.
REQ-025 SHALL drive pix_ready_o 0 while rst_n low and 1 from the first clock edge after deassertion.
REQ-026 SHALL discard any partially sent pixel on reset mid-frame; next accepted pixel is (0,0).

Configuration
REQ-027 SHALL, with PIXEL_TX_SOF_EN defined, provide m_axis_tuser asserted only with the R byte of pixel (0,0).
REQ-028 SHALL, without PIXEL_TX_SOF_EN, omit the m_axis_tuser port and its logic; all other behaviour identical.

Structure
REQ-029 SHALL place the FSM state enum, byte-phase encoding and counter width constant (12 bits) in shared package pixel_stream_pkg.
REQ-030 SHALL keep x/y counters and tlast/frame_done generation in sub-module pixel_pos_counter, stepped by a single advance strobe.

Verification
REQ-031 SHALL verify: pixel 0x112233 accepted, tready=1 -> bytes 0x11,0x22,0x33 on 3 consecutive cycles starting 1 cycle after accept.
REQ-032 SHALL verify: IMG_W=4, IMG_H=2, continuous stream of 8 pixels -> tlast on bytes 12 and 24 only, frame_done_o one pulse after byte 24, no idle cycle between pixels.
REQ-033 SHALL verify: tready low 5 cycles during G byte 0x22 -> tdata held 0x22, tvalid held 1, pix_ready_o 0 throughout.
REQ-034 SHALL verify: rst_n low after G byte of pixel (2,0) -> outputs 0 immediately; next pixel 0xAABBCC emits tuser=1 with 0xAA (with PIXEL_TX_SOF_EN).
REQ-035 SHALL verify: random tready/pix_valid, 3 frames IMG_W=4 IMG_H=3 -> byte stream equals scoreboard, exactly 3 frame_done_o pulses, 9 tlast.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: shared FSM states, byte-phase encoding and counter width for pixel_stream_tx
package pixel_stream_pkg;
  localparam int CW = 12;
  typedef enum logic [1:0] {EMPTY, SEND_R, SEND_G, SEND_B} state_t;
  typedef enum logic [1:0] {PH_B, PH_G, PH_R} phase_t;
  function automatic logic [7:0] sel_byte(input logic [23:0] pix, input phase_t ph);
    return ph == PH_R ? pix[23:16] : ph == PH_G ? pix[15:8] : pix[7:0];
  endfunction
endpackage

// File: rtl/pixel_pos_counter.sv
// pixel_pos_counter: x/y raster position, end-of-line flag and one-cycle end-of-frame pulse
module pixel_pos_counter
  import pixel_stream_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_adv,
  output logic o_first,
  output logic o_last,
  output logic o_done
);
  localparam logic [CW-1:0] XMAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] YMAX = CW'(IMG_H - 1);
  logic [CW-1:0] r_x, r_y;
  logic r_done;
  assign o_first = r_x == '0 && r_y == '0;
  assign o_last = r_x == XMAX;
  assign o_done = r_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= i_adv && o_last && r_y == YMAX;
      if (i_adv) begin
        r_x <= o_last ? '0 : r_x + 1'b1;
        if (o_last) r_y <= r_y == YMAX ? '0 : r_y + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: serializes 24-bit RGB pixels into an R,G,B byte AXI-Stream with tlast per line.
// Define PIXEL_TX_SOF_EN to add m_axis_tuser marking the first byte of each frame.
module pixel_stream_tx
  import pixel_stream_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  input  logic [23:0] pix_data_i,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
`ifdef PIXEL_TX_SOF_EN
  output logic        m_axis_tuser,
`endif
  output logic        frame_done_o
);
  state_t r_state;
  logic [23:0] r_pix;
  logic r_run;
  logic w_acc, w_hs, w_first, w_last;
  assign m_axis_tvalid = r_state != EMPTY;
  assign w_hs = m_axis_tvalid && m_axis_tready;
  // r_run holds ready low until the first edge after reset release
  assign pix_ready_o = r_run && (r_state == EMPTY || (r_state == SEND_B && m_axis_tready));
  assign w_acc = pix_valid_i && pix_ready_o;
  assign m_axis_tdata = r_state == EMPTY ? '0 :
    sel_byte(r_pix, r_state == SEND_R ? PH_R : r_state == SEND_G ? PH_G : PH_B);
  assign m_axis_tlast = r_state == SEND_B && w_last;
`ifdef PIXEL_TX_SOF_EN
  assign m_axis_tuser = r_state == SEND_R && w_first;
`else
  logic w_unused_first;
  assign w_unused_first = w_first;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_pix <= '0;
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_acc) r_pix <= pix_data_i;
      r_state <= w_acc ? SEND_R : !w_hs ? r_state :
        r_state == SEND_B ? EMPTY : state_t'(r_state + 2'd1);
    end
  end
  pixel_pos_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_adv   (w_hs && r_state == SEND_B),
    .o_first (w_first),
    .o_last  (w_last),
    .o_done  (frame_done_o)
  );
endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: two DUTs (4x2 directed, 4x3 random) checked every cycle against a pixel-level model
module tb_pixel_stream_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [1:0] rstn, valid, tready;
  logic [1:0][23:0] data;
  logic [1:0] o_ready, o_valid, o_last, o_done;
  logic [1:0][7:0] o_data;
`ifdef PIXEL_TX_SOF_EN
  logic [1:0] o_user;
`endif
  int checks = 0, errors = 0;
  int m_rem [2];
  logic [23:0] m_pix [2];
  int m_cur [2], m_n [2];
  bit m_run [2], m_dp [2], acc_flag [2];
  int a_acc_cyc[$], a_hs_cyc[$], a_done_cyc[$];
  logic [7:0] a_hs_data[$];
  bit a_hs_last[$];
  int b_bytes = 0, b_last = 0, b_done = 0;

  pixel_stream_tx #(.IMG_W(4), .IMG_H(2)) dut_a (
    .clk(clk), .rst_n(rstn[0]), .pix_valid_i(valid[0]), .pix_ready_o(o_ready[0]),
    .pix_data_i(data[0]), .m_axis_tvalid(o_valid[0]), .m_axis_tready(tready[0]),
    .m_axis_tdata(o_data[0]), .m_axis_tlast(o_last[0]),
`ifdef PIXEL_TX_SOF_EN
    .m_axis_tuser(o_user[0]),
`endif
    .frame_done_o(o_done[0]));
  pixel_stream_tx #(.IMG_W(4), .IMG_H(3)) dut_b (
    .clk(clk), .rst_n(rstn[1]), .pix_valid_i(valid[1]), .pix_ready_o(o_ready[1]),
    .pix_data_i(data[1]), .m_axis_tvalid(o_valid[1]), .m_axis_tready(tready[1]),
    .m_axis_tdata(o_data[1]), .m_axis_tlast(o_last[1]),
`ifdef PIXEL_TX_SOF_EN
    .m_axis_tuser(o_user[1]),
`endif
    .frame_done_o(o_done[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model: a pixel is 3 pending bytes; its frame position is its acceptance index since reset
  initial begin
    logic e_rdy, e_v, e_l, e_u, e_dn, hs;
    logic [7:0] e_d;
    int fsz;
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_pix[k] = '0; m_cur[k] = 0; m_n[k] = 0;
      m_run[k] = 0; m_dp[k] = 0; acc_flag[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        fsz = k == 0 ? 8 : 12;
        e_rdy = 0; e_v = 0; e_l = 0; e_u = 0; e_dn = 0; e_d = '0;
        if (rstn[k]) begin
          e_v = m_rem[k] != 0;
          e_rdy = m_run[k] && (m_rem[k] == 0 || (m_rem[k] == 1 && tready[k]));
          e_d = m_rem[k] == 3 ? m_pix[k][23:16] : m_rem[k] == 2 ? m_pix[k][15:8] : m_pix[k][7:0];
          e_l = m_rem[k] == 1 && m_cur[k] % 4 == 3;
          e_u = m_rem[k] == 3 && m_cur[k] == 0;
          e_dn = m_dp[k];
        end
        chk($sformatf("pix_ready%0d", k), o_ready[k], e_rdy);
        chk($sformatf("tvalid%0d", k), o_valid[k], e_v);
        chk($sformatf("tlast%0d", k), o_last[k], e_l);
        chk($sformatf("frame_done%0d", k), o_done[k], e_dn);
        if (e_v || !rstn[k]) chk($sformatf("tdata%0d", k), o_data[k], e_d);
`ifdef PIXEL_TX_SOF_EN
        chk($sformatf("tuser%0d", k), o_user[k], e_u);
`endif
        if (k == 0) begin
          if (o_valid[0] && tready[0]) begin
            a_hs_cyc.push_back(cyc); a_hs_data.push_back(o_data[0]); a_hs_last.push_back(o_last[0]);
          end
          if (o_done[0]) a_done_cyc.push_back(cyc);
        end else begin
          if (o_valid[1] && tready[1]) begin b_bytes++; if (o_last[1]) b_last++; end
          if (o_done[1]) b_done++;
        end
        if (!rstn[k]) begin
          m_rem[k] = 0; m_pix[k] = '0; m_cur[k] = 0; m_n[k] = 0;
          m_run[k] = 0; m_dp[k] = 0; acc_flag[k] = 0;
        end else begin
          hs = e_v && tready[k];
          acc_flag[k] = valid[k] && e_rdy;
          m_dp[k] = hs && m_rem[k] == 1 && m_cur[k] == fsz - 1;
          if (hs) m_rem[k]--;
          if (acc_flag[k]) begin
            m_pix[k] = data[k]; m_cur[k] = m_n[k] % fsz; m_n[k]++; m_rem[k] = 3;
            if (k == 0) a_acc_cyc.push_back(cyc);
          end
          m_run[k] = 1;
        end
      end
    end
  end

  task automatic run_pixels(input int k, input int n, input bit rnd, input logic [23:0] first);
    logic [23:0] px[$];
    int sent, guard;
    px.push_back(first);
    for (int i = 1; i < n; i++) px.push_back(24'($urandom));
    sent = 0; guard = 0;
    while ((sent < n || m_rem[k] != 0) && guard < 4000) begin
      @(posedge clk); #1;
      if (acc_flag[k]) sent++;
      valid[k] = sent < n && (!rnd || $urandom_range(0, 2) != 0);
      data[k] = sent < n ? px[sent] : '0;
      tready[k] = !rnd || $urandom_range(0, 3) != 0;
      guard++;
    end
    if (guard >= 4000) begin
      checks++; errors++;
      $display("FAIL stream_timeout dut%0d: sent %0d of %0d", k, sent, n);
    end
    valid[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nl;
    rstn = '0; valid = '0; tready = '0; data = '0;
    @(negedge clk);
    chk("rst_ready", o_ready[0], 0);
    chk("rst_tvalid", o_valid[0], 0);
    @(posedge clk); #1 rstn = 2'b11;
    @(negedge clk);
    chk("ready_before_edge", o_ready[0], 0);
    @(negedge clk);
    chk("ready_after_edge", o_ready[0], 1);
    // one full 4x2 frame, continuous
    run_pixels(0, 8, 0, 24'h112233);
    repeat (3) @(posedge clk);
    chk("n_bytes", a_hs_data.size(), 24);
    chk("byte_r", a_hs_data[0], 8'h11);
    chk("byte_g", a_hs_data[1], 8'h22);
    chk("byte_b", a_hs_data[2], 8'h33);
    chk("r_latency", a_hs_cyc[0] - a_acc_cyc[0], 1);
    chk("no_idle", a_hs_cyc[23] - a_hs_cyc[0], 23);
    nl = 0;
    foreach (a_hs_last[i]) nl += int'(a_hs_last[i]);
    chk("n_tlast", nl, 2);
    chk("tlast_byte12", a_hs_last[11], 1);
    chk("tlast_byte24", a_hs_last[23], 1);
    chk("n_frame_done", a_done_cyc.size(), 1);
    chk("frame_done_cyc", a_done_cyc[0] - a_hs_cyc[23], 1);
    // stall on G byte
    @(posedge clk); #1 valid[0] = 1; data[0] = 24'h112233; tready[0] = 1;
    @(posedge clk); #1 valid[0] = 0;
    @(posedge clk); #1 tready[0] = 0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_tdata", o_data[0], 8'h22);
      chk("hold_tvalid", o_valid[0], 1);
      chk("hold_ready", o_ready[0], 0);
    end
    @(posedge clk); #1 tready[0] = 1;
    repeat (4) @(posedge clk);
    run_pixels(0, 1, 0, 24'h010203);
    // reset during B byte of pixel (2,0)
    @(posedge clk); #1 valid[0] = 1; data[0] = 24'h445566; tready[0] = 1;
    @(posedge clk); #1 valid[0] = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 rstn[0] = 0; tready[0] = 0;
    #1;
    chk("rst_mid_tvalid", o_valid[0], 0);
    chk("rst_mid_tdata", o_data[0], 0);
    chk("rst_mid_tlast", o_last[0], 0);
    chk("rst_mid_ready", o_ready[0], 0);
    chk("rst_mid_done", o_done[0], 0);
    @(posedge clk); #1 rstn[0] = 1;
    @(posedge clk); #1 valid[0] = 1; data[0] = 24'hAABBCC;
    @(posedge clk); #1 valid[0] = 0;
    @(negedge clk);
    chk("after_rst_tdata", o_data[0], 8'hAA);
    chk("after_rst_tvalid", o_valid[0], 1);
`ifdef PIXEL_TX_SOF_EN
    chk("after_rst_tuser", o_user[0], 1);
`endif
    @(posedge clk); #1 tready[0] = 1;
    repeat (5) @(posedge clk);
    // three random 4x3 frames
    run_pixels(1, 36, 1, 24'($urandom));
    repeat (4) @(posedge clk);
    chk("rand_bytes", b_bytes, 108);
    chk("rand_tlast", b_last, 9);
    chk("rand_frame_done", b_done, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
